// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its clear sequencer.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int RF_ZERO_ADDR = 0;

    // Address width: never narrower than one bit, even for a two-entry file.
    function automatic int rf_aw(input int nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Sequencer that sweeps zeros through every entry after reset or on request,
// and holds the register file out of service until the sweep completes.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_req,
    output logic          ready,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_t     state_reg, state_next;
    logic [AW-1:0] clear_idx_reg, clear_idx_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RF_CLEAR;
            clear_idx_reg <= '0;
        end else begin
            state_reg     <= state_next;
            clear_idx_reg <= clear_idx_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        clear_idx_next = clear_idx_reg;
        ready          = 1'b0;
        sweep_we       = 1'b0;
        case (state_reg)
            RF_CLEAR: begin
                sweep_we = 1'b1;
                if (clear_idx_reg == LAST_IDX) begin
                    state_next     = RF_RUN;
                    clear_idx_next = '0;
                end else begin
                    clear_idx_next = clear_idx_reg + 1'b1;
                end
            end
            RF_RUN: begin
                ready = 1'b1;
                if (clear_req) begin
                    state_next     = RF_CLEAR;
                    clear_idx_next = '0;
                end
            end
            default: begin
                state_next     = RF_CLEAR;
                clear_idx_next = '0;
            end
        endcase
    end

    assign sweep_addr = clear_idx_reg;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file: prioritised multi-port writes,
// optional same-cycle bypass, write-conflict flag and a zeroing sweep.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_req,
    output logic                      ready,
    input  logic [NWR-1:0]            we,
    input  logic [NWR-1:0][AW-1:0]    waddr,
    input  logic [NWR-1:0][XLEN-1:0]  wdata,
    input  logic [NRD-1:0][AW-1:0]    raddr,
    output logic [NRD-1:0][XLEN-1:0]  rdata,
    output logic                      wr_conflict
);

    logic            sweep_we;
    logic [AW-1:0]   sweep_addr;
    logic [NWR-1:0]  wr_valid;
    logic [XLEN-1:0] mem [NREGS];

    regfile_clear_ctrl #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .ready      (ready),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // Entry 0 is hardwired when ZERO_REG is set; addresses past the depth do not exist.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_REG != 0) && (int'(a) == RF_ZERO_ADDR));
    endfunction

    for (genvar gi = 0; gi < NWR; gi++) begin : g_wr_valid
        assign wr_valid[gi] = ready && we[gi] && addr_ok(waddr[gi]);
    end

    // Later ports are scheduled last, so the highest-index port wins a shared address.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_valid[p]) begin
                    mem[waddr[p]] <= wdata[p];
                end
            end
        end
    end

    if (NWR == 2) begin : g_conflict
        assign wr_conflict = wr_valid[0] && wr_valid[1] && (waddr[0] == waddr[1]);
    end else begin : g_no_conflict
        assign wr_conflict = 1'b0;
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_read
        logic [XLEN-1:0] rd_value;

        always_comb begin
            rd_value = '0;
            if (ready && addr_ok(raddr[gi])) begin
                rd_value = mem[raddr[gi]];
            end
            if ((BYPASS != 0) && ready) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_valid[p] && (waddr[p] == raddr[gi])) begin
                        rd_value = wdata[p];
                    end
                end
            end
        end

        assign rdata[gi] = rd_value;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default, no-bypass and 24-entry instances
// share one stimulus stream and are checked against hand-computed values.
module tb_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             clear_req;
    logic [1:0]       we;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
    logic [1:0][4:0]  raddr;

    logic             ready_a, conf_a;
    logic [1:0][31:0] rdata_a;
    logic             ready_n, conf_n;
    logic [1:0][31:0] rdata_n;
    logic             ready_s, conf_s;
    logic [1:0][31:0] rdata_s;

    register_file_mp dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_a),
        .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_a), .wr_conflict(conf_a)
    );

    register_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_n),
        .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_n), .wr_conflict(conf_n)
    );

    register_file_mp #(.NREGS(24)) dut_24 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_s),
        .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_s), .wr_conflict(conf_s)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic [31:0] exp_r0, exp_r1;
        logic        exp_conf;
        logic [31:0] exp_nb_r0;
        logic [31:0] exp_s_r0;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts rising edges until each instance reports ready; -1 if it never does.
    task automatic wait_ready(output int na, output int ns);
        na = -1;
        ns = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (ns < 0 && ready_s) ns = i;
            if (na < 0 && ready_a) begin
                na = i;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < 32; r++) begin
            raddr[0] = 5'(r);
            raddr[1] = 5'(31 - r);
            #1;
            check($sformatf("%s_a_r%0d", tag, r), rdata_a[0], 32'h0);
            check($sformatf("%s_nb_r%0d", tag, r), rdata_n[1], 32'h0);
        end
    endtask

    int na, ns;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{2'b01, 5'd5,  5'd0, 32'hDEADBEEF, 32'h0,        5'd5,  5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        5'd5,  5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{2'b11, 5'd7,  5'd7, 32'h11,       32'h22,       5'd7,  5'd5, 32'h22,       32'hDEADBEEF, 1'b1, 32'h0,        32'h22};
        vecs[3]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        5'd7,  5'd0, 32'h22,       32'h0,        1'b0, 32'h22,       32'h22};
        vecs[4]  = '{2'b11, 5'd0,  5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  5'd7, 32'h0,        32'h22,       1'b0, 32'h0,        32'h0};
        vecs[5]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        5'd0,  5'd7, 32'h0,        32'h22,       1'b0, 32'h0,        32'h0};
        vecs[6]  = '{2'b11, 5'd3,  5'd9, 32'hA,        32'hB,        5'd3,  5'd9, 32'hA,        32'hB,        1'b0, 32'h0,        32'hA};
        vecs[7]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        5'd3,  5'd9, 32'hA,        32'hB,        1'b0, 32'hA,        32'hA};
        vecs[8]  = '{2'b01, 5'd30, 5'd0, 32'h12345678, 32'h0,        5'd30, 5'd3, 32'h12345678, 32'hA,        1'b0, 32'h0,        32'h0};
        vecs[9]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        5'd30, 5'd3, 32'h12345678, 32'hA,        1'b0, 32'h12345678, 32'h0};
        vecs[10] = '{2'b10, 5'd9,  5'd9, 32'h1,        32'hC,        5'd9,  5'd0, 32'hC,        32'h0,        1'b0, 32'hB,        32'hC};
        vecs[11] = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        5'd9,  5'd0, 32'hC,        32'h0,        1'b0, 32'hC,        32'hC};

        // Reset: outputs held quiet even with a would-be conflict presented.
        rst_n     = 1'b0;
        clear_req = 1'b0;
        we        = 2'b11;
        waddr[0]  = 5'd1;
        waddr[1]  = 5'd1;
        wdata[0]  = 32'h1;
        wdata[1]  = 32'h2;
        raddr[0]  = 5'd1;
        raddr[1]  = 5'd1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_a), 32'h0);
        check("rst_conf", 32'(conf_a), 32'h0);
        check("rst_rdata", rdata_a[0], 32'h0);
        we    = 2'b00;
        rst_n = 1'b1;
        wait_ready(na, ns);
        $display("reset release: ready after %0d edges (32-entry), %0d edges (24-entry)", na, ns);
        check("sweep_len_32", 32'(na), 32'd32);
        check("sweep_len_24", 32'(ns), 32'd24);
        check("ready_nb", 32'(ready_n), 32'h1);
        check_all_zero("init");

        // Table of single-cycle vectors; later rows observe writes committed by earlier rows.
        for (int i = 0; i < 12; i++) begin
            we       = vecs[i].we;
            waddr[0] = vecs[i].wa0;
            waddr[1] = vecs[i].wa1;
            wdata[0] = vecs[i].wd0;
            wdata[1] = vecs[i].wd1;
            raddr[0] = vecs[i].ra0;
            raddr[1] = vecs[i].ra1;
            #2;
            $display("vec %0d: we=%b wa=%0d/%0d ra=%0d/%0d rd=%h/%h conf=%b nb=%h s=%h",
                     i, we, waddr[0], waddr[1], raddr[0], raddr[1],
                     rdata_a[0], rdata_a[1], conf_a, rdata_n[0], rdata_s[0]);
            check($sformatf("vec%0d_r0", i), rdata_a[0], vecs[i].exp_r0);
            check($sformatf("vec%0d_r1", i), rdata_a[1], vecs[i].exp_r1);
            check($sformatf("vec%0d_conf", i), 32'(conf_a), 32'(vecs[i].exp_conf));
            check($sformatf("vec%0d_nb_r0", i), rdata_n[0], vecs[i].exp_nb_r0);
            check($sformatf("vec%0d_s_r0", i), rdata_s[0], vecs[i].exp_s_r0);
            @(posedge clk);
            #1;
        end
        we = 2'b00;

        // Asynchronous reset in RUN drops ready and rdata before any clock edge.
        we       = 2'b01;
        waddr[0] = 5'd6;
        wdata[0] = 32'h66;
        @(posedge clk);
        #1;
        we       = 2'b00;
        raddr[0] = 5'd6;
        #1;
        check("pre_async_r6", rdata_a[0], 32'h66);
        rst_n = 1'b0;
        #1;
        check("async_ready", 32'(ready_a), 32'h0);
        check("async_rdata", rdata_a[0], 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready(na, ns);
        $display("async reset: ready after %0d edges", na);
        check("async_sweep_len", 32'(na), 32'd32);

        // Fill 1..31 with their own index.
        for (int r = 1; r < 32; r++) begin
            we       = 2'b01;
            waddr[0] = 5'(r);
            wdata[0] = 32'(r);
            @(posedge clk);
            #1;
        end
        we       = 2'b00;
        raddr[0] = 5'd31;
        raddr[1] = 5'd13;
        #1;
        check("fill_r31", rdata_a[0], 32'd31);
        check("fill_r13", rdata_a[1], 32'd13);
        check("fill_nb_r31", rdata_n[0], 32'd31);

        // Clear request with a write in the same cycle, then writes during the sweep.
        clear_req = 1'b1;
        we        = 2'b01;
        waddr[0]  = 5'd4;
        wdata[0]  = 32'h99;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        check("clear_ready_low", 32'(ready_a), 32'h0);
        na = -1;
        for (int i = 1; i <= 100; i++) begin
            we       = (i <= 20) ? 2'b11 : 2'b00;
            waddr[0] = 5'd2;
            waddr[1] = 5'd3;
            wdata[0] = 32'h55;
            wdata[1] = 32'h55;
            @(posedge clk);
            #1;
            if (i <= 20 && conf_a) begin
                checks++;
                errors++;
                $display("FAIL sweep_conf_edge%0d: got 1 expected 0", i);
            end
            if (ready_a) begin
                na = i;
                break;
            end
        end
        we = 2'b00;
        $display("clear request: ready after %0d edges", na);
        check("clear_sweep_len", 32'(na), 32'd32);
        check_all_zero("clr");

        // Reset at sweep cycle 10 restarts the sweep from entry 0.
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready(na, ns);
        $display("mid-sweep reset: ready after %0d edges (32-entry), %0d edges (24-entry)", na, ns);
        check("midrst_sweep_32", 32'(na), 32'd32);
        check("midrst_sweep_24", 32'(ns), 32'd24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port integer register file; successor of the single-write, two-read core register file.
- Adds the following over the current block:
  - configurable width, depth, read-port count and write-port count
  - rising-edge writes with optional same-cycle write-to-read bypass
  - deterministic write-port priority and conflict flag
  - sequenced hardware clear after reset or on request
- Sits in the decode stage; write ports are driven by writeback (port 0) and a second retire or load-return path (port 1).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers. Range 2..256; need not be a power of two.
- NRD, 2, number of read ports (1..4).
- NWR, 2, number of write ports (1..2).
- ZERO_REG, 1, if 1 register 0 reads as zero and ignores writes.
- BYPASS, 1, if 1 a read of an address being written this cycle returns the new data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_req  in  1  request a full clear sweep; sampled only while ready=1.
- ready  out  1  1 when the array is valid and accepting writes.
- we  in  NWR  per-port write enable.
- waddr  in  NWR x AW  per-port write address, where AW = max(1, clog2(NREGS)).
- wdata  in  NWR x XLEN  per-port write data.
- raddr  in  NRD x AW  per-port read address.
- rdata  out  NRD x XLEN  per-port read data; combinational.
- wr_conflict  out  1  1 when two enabled write ports target the same valid address this cycle.

Behaviour:
- Reset (rst_n=0): state goes to CLEAR with clear_idx=0 immediately, asynchronously.
  - Outputs during reset: ready=0, wr_conflict=0, all rdata=0.
  - Array contents are don't-care until the sweep completes.
- State machine, two states: CLEAR and RUN.
- CLEAR:
  - Each rising edge writes 0 to entry clear_idx, then clear_idx increments.
  - Transitions to RUN on the edge that clears entry NREGS-1.
  - ready rises after exactly NREGS rising edges following rst_n deassertion.
  - External writes (we) and clear_req are ignored.
  - rdata=0 on all ports.
  - wr_conflict=0.
- RUN:
  - ready=1.
  - clear_req=1 at a rising edge moves the state to CLEAR with clear_idx=0. Writes presented in that same cycle are still committed, but the sweep then zeroes them.
- Reset mid-sweep: the sweep restarts from index 0.
- Write address validity: a write address is valid when it is below NREGS, and also non-zero when ZERO_REG=1. Invalid writes are dropped silently.
- Write commit: on the rising edge, each enabled port with a valid address writes its data.
- Same-address writes: if both ports target the same address, port NWR-1 (the highest index) wins, and wr_conflict=1 combinationally in that cycle.
- Read, no bypass case:
  - rdata[i] = array[raddr[i]].
  - rdata[i] = 0 if raddr[i] >= NREGS.
  - rdata[i] = 0 if ZERO_REG=1 and raddr[i]=0.
- Read, bypass case (BYPASS=1, RUN): if any enabled port writes a valid address equal to raddr[i], rdata[i] takes that port's wdata. Priority matches commit (highest index wins).
- BYPASS=0: reads return the pre-edge array contents; new data is visible the cycle after the write.
- Read latency is 0 cycles (combinational). Write-to-read latency is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.
- Array storage has no reset; only the FSM and clear_idx are asynchronously reset.

Decomposition:
- Shared package regfile_pkg holds:
  - enum rf_state_t {RF_CLEAR, RF_RUN}
  - localparam function for AW
  - constant RF_ZERO_ADDR = 0
- Sub-module regfile_clear_ctrl holds the FSM and clear_idx counter.
  - Outputs: ready, sweep_we, sweep_addr.
  - Parent muxes the sweep write ahead of the external ports.
- Top level holds the storage, write-priority logic, bypass muxes and conflict detection.

Test Plan:
- Reset release, defaults (NREGS=32): rst_n low 3 cycles then high, we=0.
  - ready=0 for 32 edges and rises after the 32nd; all reads return 0 afterwards.
- Bypass on: in RUN, we[0]=1, waddr[0]=5, wdata[0]=0xDEADBEEF, raddr[0]=5 in the same cycle.
  - rdata[0]=0xDEADBEEF in that cycle.
  - Repeat with BYPASS=0: rdata[0]=0 in that cycle and 0xDEADBEEF in the next cycle.
- Write conflict: we=2'b11, both waddr=7, wdata[0]=0x11, wdata[1]=0x22.
  - wr_conflict=1 in that cycle.
  - Next cycle reading register 7 returns 0x22.
- Zero register: write 0xFFFFFFFF to address 0 with ZERO_REG=1.
  - Register 0 reads 0; wr_conflict=0 even if both ports target address 0.
- Non-power-of-two depth (NREGS=24): write to address 30.
  - Write is dropped; reading address 30 returns 0; the sweep takes 24 cycles.
- Mid-operation clear and reset:
  - Fill registers 1..31 with their own index, then pulse clear_req. Expect ready=0 for 32 cycles, writes ignored throughout, and all registers read 0 after.
  - Assert rst_n low at sweep cycle 10. The sweep restarts from 0 and ready rises 32 edges after release.
